// File: rtl/axi4_sram_burst.sv
// AXI4 slave backed by an on-chip SRAM with FIXED/INCR/WRAP bursts and a fixed beat size.
// Read and write channels run independent FSMs; beats outside the array answer DECERR.
module axi4_sram_burst #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 1024,
   parameter int ID_WIDTH   = 4
) (
   input  logic                    i_aclk,
   input  logic                    i_areset,
   input  logic [ID_WIDTH-1:0]     i_awid,
   input  logic [ADDR_WIDTH-1:0]   i_awaddr,
   input  logic [7:0]              i_awlen,
   input  logic [1:0]              i_awburst,
   input  logic                    i_awvalid,
   output logic                    o_awready,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_wstrb,
   input  logic                    i_wlast,
   input  logic                    i_wvalid,
   output logic                    o_wready,
   output logic [ID_WIDTH-1:0]     o_bid,
   output logic [1:0]              o_bresp,
   output logic                    o_bvalid,
   input  logic                    i_bready,
   input  logic [ID_WIDTH-1:0]     i_arid,
   input  logic [ADDR_WIDTH-1:0]   i_araddr,
   input  logic [7:0]              i_arlen,
   input  logic [1:0]              i_arburst,
   input  logic                    i_arvalid,
   output logic                    o_arready,
   output logic [ID_WIDTH-1:0]     o_rid,
   output logic [DATA_WIDTH-1:0]   o_rdata,
   output logic [1:0]              o_rresp,
   output logic                    o_rlast,
   output logic                    o_rvalid,
   input  logic                    i_rready
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(DEPTH * STRB_W);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;
   typedef enum logic [1:0] {W_IDLE = 2'b00, W_DATA = 2'b01, W_RESP = 2'b10} wr_state_t;

   // Returns {slverr, effective burst}; illegal WRAP lengths and type 3 degrade to INCR.
   function automatic logic [2:0] decode_burst(input logic [1:0] burst, input logic [7:0] len);
      logic [2:0] res;
      case (burst)
         BURST_FIXED: res = {1'b0, BURST_FIXED};
         BURST_INCR:  res = {1'b0, BURST_INCR};
         BURST_WRAP: begin
            if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) res = {1'b0, BURST_WRAP};
            else res = {1'b1, BURST_INCR};
         end
         default:     res = {1'b1, BURST_INCR};
      endcase
      return res;
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [1:0] burst,
                                                       input logic [7:0] len);
      logic [ADDR_WIDTH-1:0] inc;
      logic [ADDR_WIDTH-1:0] mask;
      logic [ADDR_WIDTH-1:0] res;
      inc  = addr + ADDR_WIDTH'(STRB_W);
      mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << LSB) - ADDR_WIDTH'(1);
      case (burst)
         BURST_FIXED: res = addr;
         BURST_WRAP:  res = (addr & ~mask) | (inc & mask);
         default:     res = inc;
      endcase
      return res;
   endfunction

   function automatic logic addr_oob(input logic [ADDR_WIDTH-1:0] addr);
      return ({1'b0, addr} >= MEM_BYTES);
   endfunction

   function automatic logic [1:0] beat_resp(input logic oob, input logic err);
      logic [1:0] res;
      if (oob) res = RESP_DECERR;
      else if (err) res = RESP_SLVERR;
      else res = RESP_OKAY;
      return res;
   endfunction

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   // ---------------- read channel ----------------
   rd_state_t             rd_state_r, rd_state_nxt_s;
   logic [ADDR_WIDTH-1:0] rd_addr_r, rd_ld_addr_s;
   logic [7:0]            rd_len_r, rd_cnt_r;
   logic [1:0]            rd_burst_r, rresp_r;
   logic                  rd_err_r, rd_ld_err_s, rlast_r;
   logic [ID_WIDTH-1:0]   rid_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   logic [2:0]            ar_dec_s;
   logic                  ar_fire_s, r_fire_s, rd_load_s;

   assign ar_fire_s = i_arvalid & o_arready;
   assign r_fire_s  = o_rvalid & i_rready;
   assign rd_load_s = ar_fire_s | (r_fire_s & ~rlast_r);
   assign ar_dec_s  = decode_burst(i_arburst, i_arlen);

   // Address of the beat about to be loaded into the read data register.
   always_comb begin
      rd_ld_addr_s = next_addr(rd_addr_r, rd_burst_r, rd_len_r);
      rd_ld_err_s  = rd_err_r;
      if (ar_fire_s) begin
         rd_ld_addr_s = i_araddr;
         rd_ld_err_s  = ar_dec_s[2];
      end else begin
         rd_ld_addr_s = next_addr(rd_addr_r, rd_burst_r, rd_len_r);
         rd_ld_err_s  = rd_err_r;
      end
   end

   // Read FSM state register.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) rd_state_r <= R_IDLE;
      else rd_state_r <= rd_state_nxt_s;
   end

   // Read FSM next-state logic.
   always_comb begin
      rd_state_nxt_s = rd_state_r;
      case (rd_state_r)
         R_IDLE:  if (ar_fire_s) rd_state_nxt_s = R_DATA; else rd_state_nxt_s = R_IDLE;
         R_DATA:  if (r_fire_s && rlast_r) rd_state_nxt_s = R_IDLE; else rd_state_nxt_s = R_DATA;
         default: rd_state_nxt_s = R_IDLE;
      endcase
   end

   // Read FSM outputs.
   always_comb begin
      o_arready = 1'b0;
      o_rvalid  = 1'b0;
      case (rd_state_r)
         R_IDLE:  o_arready = 1'b1;
         R_DATA:  o_rvalid  = 1'b1;
         default: o_arready = 1'b0;
      endcase
   end

   // Read beat tracking and registered read data; SRAM sampled before any same-edge write.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         rd_addr_r  <= {ADDR_WIDTH{1'b0}};
         rd_len_r   <= 8'd0;
         rd_cnt_r   <= 8'd0;
         rd_burst_r <= 2'b00;
         rd_err_r   <= 1'b0;
         rid_r      <= {ID_WIDTH{1'b0}};
         rlast_r    <= 1'b0;
         rdata_r    <= {DATA_WIDTH{1'b0}};
         rresp_r    <= RESP_OKAY;
      end else begin
         if (ar_fire_s) begin
            rd_addr_r  <= i_araddr;
            rd_len_r   <= i_arlen;
            rd_cnt_r   <= 8'd0;
            rd_burst_r <= ar_dec_s[1:0];
            rd_err_r   <= ar_dec_s[2];
            rid_r      <= i_arid;
            rlast_r    <= (i_arlen == 8'd0);
         end else if (r_fire_s && !rlast_r) begin
            rd_addr_r <= rd_ld_addr_s;
            rd_cnt_r  <= rd_cnt_r + 8'd1;
            rlast_r   <= ((rd_cnt_r + 8'd1) == rd_len_r);
         end else if (r_fire_s) begin
            rlast_r <= 1'b0;
         end
         if (rd_load_s) begin
            if (addr_oob(rd_ld_addr_s)) rdata_r <= {DATA_WIDTH{1'b0}};
            else rdata_r <= mem_r[rd_ld_addr_s[LSB +: IDX_W]];
            rresp_r <= beat_resp(addr_oob(rd_ld_addr_s), rd_ld_err_s);
         end
      end
   end

   assign o_rid   = rid_r;
   assign o_rdata = rdata_r;
   assign o_rresp = rresp_r;
   assign o_rlast = rlast_r;

   // ---------------- write channel ----------------
   wr_state_t             wr_state_r, wr_state_nxt_s;
   logic [ADDR_WIDTH-1:0] wr_addr_r;
   logic [7:0]            wr_len_r, wr_cnt_r;
   logic [1:0]            wr_burst_r, wr_worst_r, wr_worst_nxt_s, wr_beat_resp_s, bresp_r;
   logic                  wr_err_r, wr_wlast_bad_r, wr_oob_s, wr_is_last_s, wlast_bad_s;
   logic [ID_WIDTH-1:0]   bid_r;
   logic [2:0]            aw_dec_s;
   logic                  aw_fire_s, w_fire_s, b_fire_s;

   assign aw_fire_s      = i_awvalid & o_awready;
   assign w_fire_s       = i_wvalid & o_wready;
   assign b_fire_s       = o_bvalid & i_bready;
   assign aw_dec_s       = decode_burst(i_awburst, i_awlen);
   assign wr_oob_s       = addr_oob(wr_addr_r);
   assign wr_is_last_s   = (wr_cnt_r == wr_len_r);
   assign wlast_bad_s    = (i_wlast != wr_is_last_s);
   assign wr_beat_resp_s = beat_resp(wr_oob_s, wr_err_r);
   assign wr_worst_nxt_s = (wr_beat_resp_s > wr_worst_r) ? wr_beat_resp_s : wr_worst_r;

   // Write FSM state register.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) wr_state_r <= W_IDLE;
      else wr_state_r <= wr_state_nxt_s;
   end

   // Write FSM next-state logic.
   always_comb begin
      wr_state_nxt_s = wr_state_r;
      case (wr_state_r)
         W_IDLE:  if (aw_fire_s) wr_state_nxt_s = W_DATA; else wr_state_nxt_s = W_IDLE;
         W_DATA:  if (w_fire_s && wr_is_last_s) wr_state_nxt_s = W_RESP; else wr_state_nxt_s = W_DATA;
         W_RESP:  if (b_fire_s) wr_state_nxt_s = W_IDLE; else wr_state_nxt_s = W_RESP;
         default: wr_state_nxt_s = W_IDLE;
      endcase
   end

   // Write FSM outputs.
   always_comb begin
      o_awready = 1'b0;
      o_wready  = 1'b0;
      o_bvalid  = 1'b0;
      case (wr_state_r)
         W_IDLE:  o_awready = 1'b1;
         W_DATA:  o_wready  = 1'b1;
         W_RESP:  o_bvalid  = 1'b1;
         default: o_awready = 1'b0;
      endcase
   end

   // Write beat tracking and response accumulation; a wlast mismatch overrides to SLVERR.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         wr_addr_r      <= {ADDR_WIDTH{1'b0}};
         wr_len_r       <= 8'd0;
         wr_cnt_r       <= 8'd0;
         wr_burst_r     <= 2'b00;
         wr_err_r       <= 1'b0;
         wr_worst_r     <= RESP_OKAY;
         wr_wlast_bad_r <= 1'b0;
         bid_r          <= {ID_WIDTH{1'b0}};
         bresp_r        <= RESP_OKAY;
      end else if (aw_fire_s) begin
         wr_addr_r      <= i_awaddr;
         wr_len_r       <= i_awlen;
         wr_cnt_r       <= 8'd0;
         wr_burst_r     <= aw_dec_s[1:0];
         wr_err_r       <= aw_dec_s[2];
         wr_worst_r     <= RESP_OKAY;
         wr_wlast_bad_r <= 1'b0;
         bid_r          <= i_awid;
      end else if (w_fire_s) begin
         wr_addr_r      <= next_addr(wr_addr_r, wr_burst_r, wr_len_r);
         wr_cnt_r       <= wr_cnt_r + 8'd1;
         wr_worst_r     <= wr_worst_nxt_s;
         wr_wlast_bad_r <= wr_wlast_bad_r | wlast_bad_s;
         if (wr_is_last_s) begin
            bresp_r <= (wr_wlast_bad_r | wlast_bad_s) ? RESP_SLVERR : wr_worst_nxt_s;
         end
      end
   end

   // SRAM byte-lane writes; contents survive reset.
   always_ff @(posedge i_aclk) begin
      if (w_fire_s && !wr_oob_s && !i_areset) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (i_wstrb[b]) mem_r[wr_addr_r[LSB +: IDX_W]][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   assign o_bid   = bid_r;
   assign o_bresp = bresp_r;
endmodule

// File: tb/tb_axi4_sram_burst.sv
// Directed bench for axi4_sram_burst: bursts, wrap order, strobes, backpressure, errors, reset.
module tb_axi4_sram_burst;
   logic        i_aclk = 1'b0;
   logic        i_areset = 1'b1;
   logic [3:0]  i_awid = '0, i_arid = '0;
   logic [31:0] i_awaddr = '0, i_araddr = '0;
   logic [7:0]  i_awlen = '0, i_arlen = '0;
   logic [1:0]  i_awburst = '0, i_arburst = '0;
   logic        i_awvalid = 1'b0, i_arvalid = 1'b0;
   logic [63:0] i_wdata = '0;
   logic [7:0]  i_wstrb = '0;
   logic        i_wlast = 1'b0, i_wvalid = 1'b0, i_bready = 1'b0, i_rready = 1'b0;
   logic        o_awready, o_wready, o_bvalid, o_arready, o_rlast, o_rvalid;
   logic [3:0]  o_bid, o_rid;
   logic [1:0]  o_bresp, o_rresp;
   logic [63:0] o_rdata;

   axi4_sram_burst dut (
      .i_aclk(i_aclk), .i_areset(i_areset),
      .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awburst(i_awburst),
      .i_awvalid(i_awvalid), .o_awready(o_awready),
      .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid), .o_wready(o_wready),
      .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
      .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arburst(i_arburst),
      .i_arvalid(i_arvalid), .o_arready(o_arready),
      .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
      .o_rvalid(o_rvalid), .i_rready(i_rready)
   );

   always #5 i_aclk = ~i_aclk;

   int n_checks = 0;
   int n_pass = 0;
   logic [63:0] wbuf [256];
   logic [63:0] rbuf [256];
   logic [1:0]  rrsp [256];
   logic        rlst [256];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [7:0] strb, input int last_beat,
                              input int bdelay, output logic [1:0] resp, output logic [3:0] bid);
      @(negedge i_aclk);
      i_awid = id; i_awaddr = addr; i_awlen = len; i_awburst = burst; i_awvalid = 1'b1;
      check_val("awready", o_awready, 1'b1);
      @(posedge i_aclk); #1;
      i_awvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         i_wdata = wbuf[b]; i_wstrb = strb; i_wlast = (b == last_beat); i_wvalid = 1'b1;
         @(negedge i_aclk);
         check_val("wready", o_wready, 1'b1);
         @(posedge i_aclk); #1;
      end
      i_wvalid = 1'b0; i_wlast = 1'b0;
      @(negedge i_aclk);
      check_val("bvalid", o_bvalid, 1'b1);
      resp = o_bresp; bid = o_bid;
      repeat (bdelay) begin
         @(negedge i_aclk);
         check_val("bvalid_hold", o_bvalid, 1'b1);
         check_val("bresp_hold", o_bresp, resp);
      end
      i_bready = 1'b1;
      @(posedge i_aclk); #1;
      i_bready = 1'b0;
      @(negedge i_aclk);
      check_val("aw_idle_after_b", {o_awready, o_bvalid}, 2'b10);
   endtask

   task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int stall_beat, output logic [3:0] rid);
      logic [63:0] snap;
      @(negedge i_aclk);
      i_arid = id; i_araddr = addr; i_arlen = len; i_arburst = burst; i_arvalid = 1'b1;
      check_val("arready", o_arready, 1'b1);
      @(posedge i_aclk); #1;
      i_arvalid = 1'b0; i_rready = 1'b1;
      for (int b = 0; b <= int'(len); b++) begin
         @(negedge i_aclk);
         check_val("rvalid", o_rvalid, 1'b1);
         if (b == stall_beat) begin
            i_rready = 1'b0;
            snap = o_rdata;
            repeat (3) begin
               @(negedge i_aclk);
               check_val("rdata_hold", o_rdata, snap);
               check_val("rvalid_hold", o_rvalid, 1'b1);
            end
            i_rready = 1'b1;
         end
         rbuf[b] = o_rdata; rrsp[b] = o_rresp; rlst[b] = o_rlast; rid = o_rid;
         @(posedge i_aclk); #1;
      end
      i_rready = 1'b0;
      @(negedge i_aclk);
      check_val("r_idle_gap", {o_arready, o_rvalid}, 2'b10);
   endtask

   logic [1:0] resp;
   logic [3:0] bid, rid;
   int errs;

   initial begin
      // Reset values
      repeat (2) @(negedge i_aclk);
      check_val("rst_ready", {o_awready, o_arready}, 2'b11);
      check_val("rst_valid", {o_wready, o_bvalid, o_rvalid, o_rlast}, 4'b0000);
      check_val("rst_resp_id", {o_bresp, o_rresp, o_bid, o_rid}, 12'h000);
      check_val("rst_rdata", o_rdata, 64'h0);
      i_areset = 1'b0;

      // Prefill words 0x00..0x38 with A0..A7
      for (int i = 0; i < 8; i++) wbuf[i] = 64'hA0 + 64'(i);
      write_burst(4'd1, 32'h0, 8'd7, 2'b01, 8'hFF, 7, 0, resp, bid);
      check_val("prefill_bresp", resp, 2'b00);
      check_val("prefill_bid", bid, 4'd1);

      // INCR write/read at 0x40
      for (int i = 0; i < 4; i++) wbuf[i] = 64'(i + 1);
      write_burst(4'd5, 32'h40, 8'd3, 2'b01, 8'hFF, 3, 0, resp, bid);
      check_val("incr_bresp", resp, 2'b00);
      check_val("incr_bid", bid, 4'd5);
      read_burst(4'd9, 32'h40, 8'd3, 2'b01, -1, rid);
      check_val("incr_rid", rid, 4'd9);
      for (int b = 0; b < 4; b++) begin
         check_val("incr_rdata", rbuf[b], 64'(b + 1));
         check_val("incr_rlast", rlst[b], (b == 3));
         check_val("incr_rresp", rrsp[b], 2'b00);
      end

      // WRAP len 3 from 0x18 -> 0x18,0x00,0x08,0x10
      read_burst(4'd2, 32'h18, 8'd3, 2'b10, -1, rid);
      check_val("wrap_d0", rbuf[0], 64'hA3);
      check_val("wrap_d1", rbuf[1], 64'hA0);
      check_val("wrap_d2", rbuf[2], 64'hA1);
      check_val("wrap_d3", rbuf[3], 64'hA2);
      check_val("wrap_resp", {rrsp[0], rrsp[3]}, 4'b0000);

      // WRAP len 2 is illegal -> INCR order with SLVERR
      read_burst(4'd2, 32'h18, 8'd2, 2'b10, -1, rid);
      check_val("badwrap_d", {rbuf[0][7:0], rbuf[1][7:0], rbuf[2][7:0]}, 24'hA3A4A5);
      check_val("badwrap_resp", {rrsp[0], rrsp[1], rrsp[2]}, 6'b101010);

      // Burst type 3 -> INCR with SLVERR; FIXED holds the address
      read_burst(4'd4, 32'h0, 8'd1, 2'b11, -1, rid);
      check_val("type3_d", {rbuf[0][7:0], rbuf[1][7:0]}, 16'hA0A1);
      check_val("type3_resp", {rrsp[0], rrsp[1]}, 4'b1010);
      read_burst(4'd4, 32'h8, 8'd2, 2'b00, -1, rid);
      check_val("fixed_d", {rbuf[0][7:0], rbuf[1][7:0], rbuf[2][7:0]}, 24'hA1A1A1);

      // Byte strobes
      wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      write_burst(4'd3, 32'h100, 8'd0, 2'b01, 8'hFF, 0, 0, resp, bid);
      wbuf[0] = 64'h0;
      write_burst(4'd3, 32'h100, 8'd0, 2'b01, 8'h0F, 0, 0, resp, bid);
      read_burst(4'd3, 32'h100, 8'd0, 2'b01, -1, rid);
      check_val("strb_rdata", rbuf[0], 64'hFFFF_FFFF_0000_0000);
      check_val("strb_rlast", rlst[0], 1'b1);

      // Read backpressure mid-burst and delayed bready
      read_burst(4'd7, 32'h0, 8'd7, 2'b01, 3, rid);
      for (int b = 0; b < 8; b++) check_val("bp_rdata", rbuf[b], 64'hA0 + 64'(b));
      wbuf[0] = 64'h55;
      write_burst(4'd6, 32'h108, 8'd0, 2'b01, 8'hFF, 0, 3, resp, bid);
      check_val("bdelay_bresp", resp, 2'b00);

      // Out-of-range single beat and burst crossing the top of the array
      wbuf[0] = 64'hDEAD;
      write_burst(4'd8, 32'h2000, 8'd0, 2'b01, 8'hFF, 0, 0, resp, bid);
      check_val("oob_bresp", resp, 2'b11);
      wbuf[0] = 64'hC0; wbuf[1] = 64'hC1;
      write_burst(4'd8, 32'h1FF8, 8'd1, 2'b01, 8'hFF, 1, 0, resp, bid);
      check_val("edge_bresp", resp, 2'b11);
      read_burst(4'd8, 32'h1FF8, 8'd1, 2'b01, -1, rid);
      check_val("edge_d0", rbuf[0], 64'hC0);
      check_val("edge_d1", rbuf[1], 64'h0);
      check_val("edge_resp", {rrsp[0], rrsp[1]}, 4'b0011);
      read_burst(4'd8, 32'h0, 8'd0, 2'b01, -1, rid);
      check_val("oob_no_alias", rbuf[0], 64'hA0);

      // Early wlast -> SLVERR, data still written
      for (int i = 0; i < 4; i++) wbuf[i] = 64'hB0 + 64'(i);
      write_burst(4'd9, 32'h200, 8'd3, 2'b01, 8'hFF, 1, 0, resp, bid);
      check_val("wlast_bresp", resp, 2'b10);
      read_burst(4'd9, 32'h200, 8'd3, 2'b01, -1, rid);
      for (int b = 0; b < 4; b++) check_val("wlast_rdata", rbuf[b], 64'hB0 + 64'(b));

      // 256-beat burst
      for (int i = 0; i < 256; i++) wbuf[i] = 64'h1000 + 64'(i);
      write_burst(4'd2, 32'h800, 8'd255, 2'b01, 8'hFF, 255, 0, resp, bid);
      check_val("long_bresp", resp, 2'b00);
      read_burst(4'd6, 32'h800, 8'd255, 2'b01, -1, rid);
      errs = 0;
      for (int i = 0; i < 256; i++)
         if (rbuf[i] !== 64'h1000 + 64'(i) || rlst[i] !== (i == 255)) errs++;
      check_val("long_rd_errs", 64'(errs), 64'd0);

      // Reset while read beat 2 of a len-7 burst is presented
      @(negedge i_aclk);
      i_arid = 4'd3; i_araddr = 32'h0; i_arlen = 8'd7; i_arburst = 2'b01; i_arvalid = 1'b1;
      @(posedge i_aclk); #1;
      i_arvalid = 1'b0; i_rready = 1'b1;
      repeat (2) begin @(negedge i_aclk); @(posedge i_aclk); #1; end
      @(negedge i_aclk);
      check_val("rst_beat2", o_rdata, 64'hA2);
      i_rready = 1'b0; i_areset = 1'b1;
      @(negedge i_aclk);
      check_val("midrst_state", {o_rvalid, o_arready, o_rlast}, 3'b010);
      check_val("midrst_rdata", o_rdata, 64'h0);
      i_areset = 1'b0;
      read_burst(4'd1, 32'h40, 8'd3, 2'b01, -1, rid);
      for (int b = 0; b < 4; b++) check_val("post_rst_rdata", rbuf[b], 64'(b + 1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
